// File: rtl/multicycle_controller.sv
// Main FSM sequencer for the multi-cycle RV32I datapath: one shared ALU, one unified
// memory port. Only the state is registered; every control output is decoded from state and inputs.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] immsrc,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  state_t state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  assign state = state_reg;

  always_comb begin
    case (op)
      OP_LOAD, OP_ITYPE: immsrc = 3'b000;
      OP_LUI:            immsrc = 3'b001;
      OP_STORE:          immsrc = 3'b010;
      OP_BRANCH:         immsrc = 3'b011;
      OP_JAL:            immsrc = 3'b100;
      default:           immsrc = 3'b000;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form oldPC+imm in ALUOut for branch/jump targets.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        mem_read   = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Only beq/bne are taken; other funct3 encodings fall through.
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        pc_write   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table of inputs and
// expected outputs, plus hand-written reset and mid-instruction abort sequences.
module tb_multicycle_controller;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] SYS = 7'b1110011;

  // {adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, illegal}
  localparam logic [7:0] F_FETCH = 8'b0101_1000;
  localparam logic [7:0] F_FWAIT = 8'b0100_0000;
  localparam logic [7:0] F_NONE  = 8'b0000_0000;
  localparam logic [7:0] F_MRD   = 8'b1100_0000;
  localparam logic [7:0] F_WB    = 8'b0000_0110;
  localparam logic [7:0] F_MWR   = 8'b1010_0000;
  localparam logic [7:0] F_MWRD  = 8'b1010_0010;
  localparam logic [7:0] F_BR_T  = 8'b0000_1010;
  localparam logic [7:0] F_BR_N  = 8'b0000_0010;
  localparam logic [7:0] F_JAL   = 8'b0000_1000;
  localparam logic [7:0] F_ILL   = 8'b0000_0011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [2:0] immsrc;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, illegal;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .immsrc(immsrc), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [22:0] expv;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic [6:0] o, input logic [2:0] f, input logic z, input logic r,
                     input logic [3:0] st, input logic [2:0] imm, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] aop, input logic [1:0] res,
                     input logic [7:0] flags);
    vecs[nvec].op   = o;
    vecs[nvec].f3   = f;
    vecs[nvec].z    = z;
    vecs[nvec].rdy  = r;
    vecs[nvec].expv = {st, imm, a, b, aop, res, flags};
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [22:0] outs();
    return {state, immsrc, alu_src_a, alu_src_b, alu_op, result_src,
            adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, illegal};
  endfunction

  initial begin
    // load, one MEMREAD wait
    add(LD, 0, 0, 1, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(LD, 0, 0, 1, 1, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(LD, 0, 0, 1, 2, 3'b000, 2'b10, 2'b01, 2'b00, 2'b00, F_NONE);
    add(LD, 0, 0, 0, 3, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, F_MRD);
    add(LD, 0, 0, 1, 3, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, F_MRD);
    add(LD, 0, 0, 1, 4, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, F_WB);
    // store, two MEMWRITE waits
    add(ST, 0, 0, 1, 0, 3'b010, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(ST, 0, 0, 1, 1, 3'b010, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(ST, 0, 0, 1, 2, 3'b010, 2'b10, 2'b01, 2'b00, 2'b00, F_NONE);
    add(ST, 0, 0, 0, 5, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00, F_MWR);
    add(ST, 0, 0, 0, 5, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00, F_MWR);
    add(ST, 0, 0, 1, 5, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00, F_MWRD);
    // R-type, one FETCH wait
    add(RT, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, F_FWAIT);
    add(RT, 0, 0, 1, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(RT, 0, 0, 1, 1, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(RT, 0, 0, 1, 6, 3'b000, 2'b10, 2'b00, 2'b10, 2'b00, F_NONE);
    add(RT, 0, 0, 1, 8, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, F_WB);
    // I-type
    add(IT, 0, 0, 1, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(IT, 0, 0, 1, 1, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(IT, 0, 0, 1, 7, 3'b000, 2'b10, 2'b01, 2'b10, 2'b00, F_NONE);
    add(IT, 0, 0, 1, 8, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, F_WB);
    // branches: beq taken, bne not taken, blt never, bne taken, beq not taken
    add(BR, 0, 1, 1, 0, 3'b011, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(BR, 0, 1, 1, 1, 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(BR, 0, 1, 1, 9, 3'b011, 2'b10, 2'b00, 2'b01, 2'b00, F_BR_T);
    add(BR, 1, 1, 1, 0, 3'b011, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(BR, 1, 1, 1, 1, 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(BR, 1, 1, 1, 9, 3'b011, 2'b10, 2'b00, 2'b01, 2'b00, F_BR_N);
    add(BR, 4, 0, 1, 0, 3'b011, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(BR, 4, 0, 1, 1, 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(BR, 4, 0, 1, 9, 3'b011, 2'b10, 2'b00, 2'b01, 2'b00, F_BR_N);
    add(BR, 1, 0, 1, 0, 3'b011, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(BR, 1, 0, 1, 1, 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(BR, 1, 0, 1, 9, 3'b011, 2'b10, 2'b00, 2'b01, 2'b00, F_BR_T);
    add(BR, 0, 0, 1, 0, 3'b011, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(BR, 0, 0, 1, 1, 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(BR, 0, 0, 1, 9, 3'b011, 2'b10, 2'b00, 2'b01, 2'b00, F_BR_N);
    // jal
    add(JL, 0, 0, 1, 0, 3'b100, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(JL, 0, 0, 1, 1, 3'b100, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(JL, 0, 0, 1, 10, 3'b100, 2'b01, 2'b10, 2'b00, 2'b00, F_JAL);
    add(JL, 0, 0, 1, 8, 3'b100, 2'b00, 2'b00, 2'b00, 2'b00, F_WB);
    // lui
    add(LU, 0, 0, 1, 0, 3'b001, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(LU, 0, 0, 1, 1, 3'b001, 2'b01, 2'b01, 2'b00, 2'b00, F_NONE);
    add(LU, 0, 0, 1, 11, 3'b001, 2'b11, 2'b01, 2'b00, 2'b00, F_NONE);
    add(LU, 0, 0, 1, 8, 3'b001, 2'b00, 2'b00, 2'b00, 2'b00, F_WB);
    // illegal opcode, then parked in FETCH
    add(SYS, 0, 0, 1, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, F_FETCH);
    add(SYS, 0, 0, 1, 1, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, F_ILL);
    add(SYS, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, F_FWAIT);

    // Reset held with memory not ready
    op = LD; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd1);
      check("rst_pc_write", 32'(pc_write), 32'd0);
    end
    mem_ready = 1'b1; rst_n = 1'b1;
    @(negedge clk); #2;
    check("rel_decode", 32'(state), 32'd1);

    // Asynchronous reset back to FETCH, then align to a negedge
    rst_n = 1'b0; mem_ready = 1'b0; #1;
    check("async_rst", 32'(state), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < nvec; i++) begin
      op = vecs[i].op; funct3 = vecs[i].f3; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #2;
      n_vec++;
      if (outs() !== vecs[i].expv) begin
        n_bad++;
        $display("FAIL vec%0d: got %b expected %b (st/imm/a/b/aop/res/flags)",
                 i, outs(), vecs[i].expv);
      end
      @(negedge clk);
    end

    // Load aborted by reset while waiting in MEMREAD
    op = LD; mem_ready = 1'b1; #2;
    check("abort_fetch", 32'(state), 32'd0);
    @(negedge clk); #2;
    check("abort_decode", 32'(state), 32'd1);
    @(negedge clk); mem_ready = 1'b0; #2;
    check("abort_memadr", 32'(state), 32'd2);
    @(negedge clk); #2;
    check("abort_memread", {28'd0, state}, {28'd0, 4'd3});
    check("abort_mrd_strobe", 32'(mem_read), 32'd1);
    rst_n = 1'b0; #1;
    check("abort_async_state", 32'(state), 32'd0);
    check("abort_no_wr", 32'(reg_write), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("abort_hold_state", 32'(state), 32'd0);
    check("abort_no_done", {30'd0, reg_write, instr_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_restart", 32'(state), 32'd1);
    check("abort_restart_wr", 32'(reg_write), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state sequencer for the multi-cycle RV32I datapath. Each instruction runs in several cycles over one shared ALU and one unified instruction/data memory port. Every cycle the block drives the datapath mux selects, write enables and memory strobes, plus `immsrc` for the sign extender. It handles memory wait states through a `mem_ready` handshake and pulses `instr_done` once per retired instruction.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction[6:0] from the instruction register.
- `funct3` in 3: instruction[14:12].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `immsrc` out 3: extender select.
  - 000 I
  - 001 U
  - 010 S
  - 011 B
  - 100 J
- `alu_src_a` out 2: ALU A operand.
  - 00 PC
  - 01 oldPC
  - 10 rs1
  - 11 zero
- `alu_src_b` out 2: ALU B operand.
  - 00 rs2
  - 01 imm
  - 10 constant 4
- `alu_op` out 2: ALU operation.
  - 00 add
  - 01 subtract
  - 10 decode funct fields
- `result_src` out 2: result bus source.
  - 00 ALUOut
  - 01 read data
  - 10 ALU result
- `adr_src` out 1: memory address source. 0 PC, 1 result bus.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: load the instruction register and oldPC.
- `pc_write` out 1: load PC from the result bus.
- `reg_write` out 1: register file write enable.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11.
- Codes 12–15 are unreachable and transition to FETCH.
- Any output not listed for a state is 0.
- `immsrc` is combinational from `op` in every state:
  - 0000011 / 0010011: 000
  - 0110111: 001
  - 0100011: 010
  - 1100011: 011
  - 1101111: 100
  - anything else: 000
- FETCH:
  - Outputs: `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Next state: DECODE if `mem_ready`, else stay in FETCH.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00. This computes the branch/jump target into ALUOut.
  - Next state by `op`:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - anything else → FETCH, with `illegal`=1 and `instr_done`=1.
- MEMADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - Next state: MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD:
  - Outputs: `adr_src`=1, `result_src`=00, `mem_read`=1.
  - Next state: MEMWB on `mem_ready`, else stay.
- MEMWB:
  - Outputs: `result_src`=01, `reg_write`=1, `instr_done`=1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: `adr_src`=1, `result_src`=00, `mem_write`=1.
  - On `mem_ready`: `instr_done`=1 and go to FETCH. Otherwise stay, holding `mem_write` high.
- EXECR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10.
  - Next state: ALUWB.
- EXECI:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: `result_src`=00, `reg_write`=1, `instr_done`=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `instr_done`=1.
  - `pc_write` = (`funct3`=000 & `zero`) | (`funct3`=001 & !`zero`). Any other `funct3` never branches.
  - Next state: FETCH.
- JAL:
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1.
  - PC takes the target; ALUOut captures oldPC+4.
  - Next state: ALUWB, which writes rd.
- LUI:
  - Outputs: `alu_src_a`=11, `alu_src_b`=01, `alu_op`=00.
  - Next state: ALUWB.

## Timing
- Only `state` is registered. All other outputs are combinational from `state`, `op`, `funct3`, `zero` and `mem_ready`.
- Reset (`rst_n` low) immediately forces `state`=FETCH. Outputs then show the FETCH values with `ir_write`/`pc_write` following `mem_ready`; every other strobe is 0.
- Reset asserted mid-instruction aborts it. No `reg_write`, `mem_write` or `instr_done` is issued for the aborted instruction.
- Cycles per instruction with zero memory wait:
  - load 5
  - store 4
  - R-type 4
  - I-type 4
  - branch 3
  - jal 4
  - lui 4
  - illegal 2
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Address and strobes hold stable while waiting.
- `mem_read` and `mem_write` are never asserted together.
- At most one of `pc_write` and `reg_write` is high in any cycle.

## Test plan
- Reset with `mem_ready`=0 held for 3 cycles → `state`=0, `mem_read`=1, `pc_write`=0. Release with `mem_ready`=1 → DECODE next cycle.
- Load (`op`=0000011), memory always ready → states 0,1,2,3,4. `reg_write` and `instr_done` only in state 4. `immsrc`=000 throughout.
- Store (`op`=0100011) with `mem_ready` low for 2 cycles in MEMWRITE → `mem_write` high for 3 cycles. `instr_done` in the third. `immsrc`=010.
- Branch (`op`=1100011): `funct3`=000 with `zero`=1 → `pc_write`=1; `funct3`=001 with `zero`=1 → `pc_write`=0; `funct3`=100 → `pc_write`=0. All complete in 3 cycles with `immsrc`=011.
- JAL then LUI → states 0,1,10,8 with `pc_write` in 10 and `immsrc`=100, then states 0,1,11,8 with `alu_src_a`=11 and `immsrc`=001. Opcode 1110011 → `illegal` pulse in DECODE, then FETCH.
- `rst_n` dropped while in MEMREAD → `state`=0 without waiting for a clock edge. No `reg_write` for that load.
